// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces NUM_BTNS active-low buttons with a single
// shared debounce timer. Each button runs a small tracking FSM; a round-robin
// scheduler lends the timer to one released button at a time and emits a
// one-cycle press pulse when the button is still released at terminal count.
module debounce_scheduler #(
  parameter int NUM_BTNS       = 4,
  parameter int DEBOUNCE_COUNT = 2399999,
  parameter int CNT_WIDTH      = 22
) (
  input  logic                clk,
  input  logic                rst_btn,
  input  logic [NUM_BTNS-1:0] btn,
  output logic [NUM_BTNS-1:0] press_pulse,
  output logic [NUM_BTNS-1:0] grant,
  output logic [NUM_BTNS-1:0] pending,
  output logic                busy
);

  localparam int                   PTR_W   = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
  localparam logic [CNT_WIDTH-1:0] TERM    = CNT_WIDTH'(DEBOUNCE_COUNT);
  localparam logic [PTR_W-1:0]     PTR_RST = PTR_W'(NUM_BTNS - 1);
  localparam logic [NUM_BTNS-1:0]  ONE_HOT = {{(NUM_BTNS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    B_HIGH = 2'd0,
    B_LOW  = 2'd1,
    B_REQ  = 2'd2,
    B_WAIT = 2'd3
  } btn_state_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TIMING = 2'd1
  } sch_state_e;

  // Round-robin search: first requesting index after ptr, wrapping around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [PTR_W-1:0]    ptr,
                                                input logic [NUM_BTNS-1:0] req);
    logic [PTR_W-1:0] sel;
    logic [PTR_W-1:0] ix;
    logic             found;
    int               idx;
    sel   = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_BTNS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_BTNS) begin
        idx = idx - NUM_BTNS;
      end
      ix = PTR_W'(idx);
      if (!found && req[ix]) begin
        found = 1'b1;
        sel   = ix;
      end
    end
    return sel;
  endfunction

  // Reset: asserted asynchronously by rst_btn low, released on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  // Reset release shift path.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops; cleared straight from the pin.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  logic [NUM_BTNS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  btn_state_e           btn_st_q [NUM_BTNS];
  btn_state_e           btn_st_d [NUM_BTNS];
  sch_state_e           sch_q, sch_d;
  logic [CNT_WIDTH-1:0] timer_q, timer_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_BTNS-1:0]  grant_q, grant_d;
  logic [NUM_BTNS-1:0]  pulse_q, pulse_d;
  logic [NUM_BTNS-1:0]  pending_q, pending_d;
  logic                 busy_q, busy_d;
  logic [NUM_BTNS-1:0]  cand_s;
  logic [NUM_BTNS-1:0]  grant_new_s;
  logic                 term_s;

  // Two-flop synchronizer inputs for the raw buttons.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  // A button may be granted only while requesting and still released.
  always_comb begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      cand_s[i] = (btn_st_q[i] == B_REQ) && sync2_q[i];
    end
    term_s = (sch_q == S_TIMING) && (timer_q == TERM);
  end

  // Scheduler next state: arbitration, timer and end-of-debounce pulse.
  always_comb begin
    sch_d       = sch_q;
    timer_d     = timer_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    pulse_d     = '0;
    grant_new_s = '0;
    case (sch_q)
      S_IDLE: begin
        timer_d = '0;
        if (|cand_s) begin
          sch_d       = S_TIMING;
          ptr_d       = rr_pick(ptr_q, cand_s);
          grant_new_s = ONE_HOT << rr_pick(ptr_q, cand_s);
          grant_d     = grant_new_s;
        end else begin
          grant_d = '0;
        end
      end
      S_TIMING: begin
        if (term_s) begin
          // Grant is held one more cycle (alongside the pulse) and is
          // replaced or cleared by the IDLE arbitration that follows.
          sch_d   = S_IDLE;
          timer_d = '0;
          if (sync2_q[ptr_q]) begin
            pulse_d[ptr_q] = 1'b1;
          end else begin
            pulse_d = '0;
          end
        end else begin
          timer_d = timer_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        sch_d   = S_IDLE;
        timer_d = '0;
        ptr_d   = PTR_RST;
        grant_d = '0;
      end
    endcase
  end

  // Per-button tracking FSMs plus registered pending/busy flags.
  always_comb begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      btn_st_d[i] = btn_st_q[i];
      case (btn_st_q[i])
        B_HIGH: begin
          if (!sync2_q[i]) btn_st_d[i] = B_LOW;
          else             btn_st_d[i] = B_HIGH;
        end
        B_LOW: begin
          if (sync2_q[i]) btn_st_d[i] = B_REQ;
          else            btn_st_d[i] = B_LOW;
        end
        B_REQ: begin
          // A press in the same cycle withdraws the request before any grant.
          if (!sync2_q[i])         btn_st_d[i] = B_LOW;
          else if (grant_new_s[i]) btn_st_d[i] = B_WAIT;
          else                     btn_st_d[i] = B_REQ;
        end
        B_WAIT: begin
          // Orphaned wait (timer no longer ours) falls back to B_LOW.
          if ((sch_q != S_TIMING) || !grant_q[i]) btn_st_d[i] = B_LOW;
          else if (term_s && sync2_q[i])          btn_st_d[i] = B_HIGH;
          else if (term_s)                        btn_st_d[i] = B_LOW;
          else                                    btn_st_d[i] = B_WAIT;
        end
        default: btn_st_d[i] = B_HIGH;
      endcase
      pending_d[i] = (btn_st_d[i] == B_REQ);
    end
    busy_d = (sch_d == S_TIMING);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      sch_q     <= S_IDLE;
      timer_q   <= '0;
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        btn_st_q[i] <= B_HIGH;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sch_q     <= sch_d;
      timer_q   <= timer_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_BTNS; i++) begin
        btn_st_q[i] <= btn_st_d[i];
      end
    end
  end

  assign press_pulse = pulse_q;
  assign grant       = grant_q;
  assign pending     = pending_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (4 buttons, terminal count 15).
// Expected press pulses (button, cycle) go into a scoreboard queue when the
// stimulus that causes them is applied; a monitor pops them as pulses appear.
module tb_debounce_scheduler;

  logic       clk;
  logic       rst_btn;
  logic [3:0] btn;
  logic [3:0] press_pulse;
  logic [3:0] grant;
  logic [3:0] pending;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_e;

  debounce_scheduler #(
    .NUM_BTNS      (4),
    .DEBOUNCE_COUNT(15),
    .CNT_WIDTH     (22)
  ) dut (
    .clk        (clk),
    .rst_btn    (rst_btn),
    .btn        (btn),
    .press_pulse(press_pulse),
    .grant      (grant),
    .pending    (pending),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input logic [3:0] mask, input int low, output int cr);
    btn = btn & ~mask;
    tick(low);
    btn = btn | mask;
    cr  = cyc;
  endtask

  task automatic wait_grant(input logic [3:0] mask, output int g);
    int n;
    n = 0;
    while (grant !== mask && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_grant", 32'(grant), 32'(mask));
    g = cyc;
  endtask

  task automatic push_exp(input int idx, input int c);
    exp_t e;
    e.idx = idx;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Monitor: one-hot outputs every cycle, and every pulse matched to the scoreboard.
  always @(negedge clk) begin
    check("onehot", {30'd0, $onehot0(grant), $onehot0(press_pulse)}, 32'd3);
    if (press_pulse !== 4'd0) begin
      vectors++;
      assert (sb_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_pulse: observed=%0h expected=none (cycle %0d)", press_pulse, cyc);
      end
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        check("pulse_bit", 32'(press_pulse), 32'd1 << exp_e.idx);
        check("pulse_cycle", cyc, exp_e.cyc);
      end
    end
  end

  initial begin
    int cr, g, g2, d;
    btn     = 4'hF;
    rst_btn = 1'b1;
    #2 rst_btn = 1'b0;
    tick(3);
    check("reset_outputs", {19'd0, press_pulse, grant, pending, busy}, 32'd0);
    rst_btn = 1'b1;
    tick(5);
    check("post_reset_outputs", {19'd0, press_pulse, grant, pending, busy}, 32'd0);

    // Clean press on button 0.
    press_release(4'b0001, 6, cr);
    tick(2);
    check("t1_pending_early", 32'(pending), 32'd0);
    tick(1);
    check("t1_pending_rise", 32'(pending), 32'h1);
    check("t1_no_grant_yet", 32'(grant), 32'd0);
    wait_grant(4'b0001, g);
    check("t1_grant_cycle", g, cr + 4);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_pending_clear", 32'(pending), 32'd0);
    push_exp(0, g + 16);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      check("t1_grant_held", 32'(grant), 32'h1);
      if (k == 15) check("t1_busy_term", 32'(busy), 32'd1);
    end
    tick(1);
    check("t1_grant_drop", {27'd0, grant, busy}, 32'd0);
    tick(3);
    check("t1_sb_empty", sb_q.size(), 32'd0);

    // Bounce on button 1: pressed again in grant cycle 5.
    press_release(4'b0010, 6, cr);
    wait_grant(4'b0010, g);
    check("t2_grant_cycle", g, cr + 4);
    tick(5);
    btn[1] = 1'b0;
    tick(15);
    check("t2_after_bounce", {23'd0, grant, pending, busy}, 32'd0);
    tick(3);
    btn[1] = 1'b1;
    cr = cyc;
    wait_grant(4'b0010, g2);
    check("t2_regrant_cycle", g2, cr + 4);
    push_exp(1, g2 + 16);
    tick(20);
    check("t2_sb_empty", sb_q.size(), 32'd0);

    // Simultaneous release of buttons 0 and 2 straight after reset.
    rst_btn = 1'b0;
    tick(2);
    rst_btn = 1'b1;
    tick(5);
    press_release(4'b0101, 6, cr);
    wait_grant(4'b0001, g);
    check("t3_grant0_cycle", g, cr + 4);
    check("t3_pending2", 32'(pending), 32'h4);
    push_exp(0, g + 16);
    push_exp(2, g + 33);
    wait_grant(4'b0100, g2);
    check("t3_grant2_cycle", g2, g + 17);
    tick(20);
    check("t3_sb_empty", sb_q.size(), 32'd0);

    // Fairness: serve button 3, then buttons 0 and 3 together.
    press_release(4'b1000, 6, cr);
    wait_grant(4'b1000, g);
    check("t4_grant3_cycle", g, cr + 4);
    push_exp(3, g + 16);
    tick(20);
    press_release(4'b1001, 6, cr);
    wait_grant(4'b0001, g);
    check("t4_grant0_first", g, cr + 4);
    push_exp(0, g + 16);
    push_exp(3, g + 33);
    wait_grant(4'b1000, g2);
    check("t4_grant3_next", g2, g + 17);
    tick(20);
    check("t4_sb_empty", sb_q.size(), 32'd0);

    // Withdrawal: button 2 requests during button 1 timing, then presses again.
    press_release(4'b0010, 6, cr);
    wait_grant(4'b0010, g);
    push_exp(1, g + 16);
    press_release(4'b0100, 4, cr);
    tick(2);
    check("t5_pending2_early", 32'(pending[2]), 32'd0);
    tick(1);
    check("t5_pending2_rise", 32'(pending), 32'h4);
    tick(1);
    btn[2] = 1'b0;
    d = cyc;
    tick(2);
    check("t5_pending2_held", 32'(pending), 32'h4);
    tick(1);
    check("t5_pending2_drop", 32'(pending), 32'd0);
    check("t5_drop_cycle", cyc, d + 3);
    for (int k = 0; k < 25; k++) begin
      tick(1);
      check("t5_no_grant2", 32'(grant[2]), 32'd0);
    end
    check("t5_sb_empty", sb_q.size(), 32'd0);

    // Reset in grant cycle 8 of button 0; button 2 is still held low.
    press_release(4'b0001, 6, cr);
    wait_grant(4'b0001, g);
    tick(8);
    rst_btn = 1'b0;
    #1;
    check("t6_async_clear", {19'd0, press_pulse, grant, pending, busy}, 32'd0);
    tick(3);
    rst_btn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      check("t6_quiet", {23'd0, grant, pending, busy}, 32'd0);
    end
    btn[2] = 1'b1;
    cr = cyc;
    wait_grant(4'b0100, g);
    check("t6_grant2_cycle", g, cr + 4);
    push_exp(2, g + 16);
    tick(20);
    check("t6_sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces NUM_BTNS active-low push buttons using one shared debounce timer instead of one timer per button.
- Each button has a small tracking FSM. A round-robin scheduler hands the single timer to one released button at a time.
- Emits a one-cycle press pulse per validated press. Sits between board buttons and counters/LED logic.

Parameters:
- NUM_BTNS, 4, number of buttons; >=2.
- DEBOUNCE_COUNT, 2399999, terminal timer value; 200 ms at 12 MHz. Set to 15 in simulation.
- CNT_WIDTH, 22, timer width; must hold DEBOUNCE_COUNT.

Ports:
- clk  input  1  12 MHz system clock.
- rst_btn  input  1  asynchronous, active-low reset; internally rst = ~rst_btn.
- btn  input  NUM_BTNS  raw active-low buttons; asynchronous to clk.
- press_pulse  output  NUM_BTNS  one-cycle pulse per validated press.
- grant  output  NUM_BTNS  one-hot; the button currently owning the timer.
- pending  output  NUM_BTNS  button is released and waiting for the timer.
- busy  output  1  timer in use.

Behaviour:
- Reset (async assert, sync deassert via clk): all outputs 0; timer 0; all button FSMs B_HIGH; scheduler IDLE; synchronizer flops 1; RR pointer NUM_BTNS-1, so button 0 wins first.
- Input sync: 2-flop synchronizer per button; 2-cycle latency. All FSM decisions use the synced value s[i].
- Button FSM, per i:
  - B_HIGH: s[i]==0 -> B_LOW.
  - B_LOW: s[i]==1 -> B_REQ.
  - B_REQ (pending[i]=1): s[i]==0 -> B_LOW (request withdrawn). Granted -> B_WAIT. Withdrawal wins over a grant issued in the same cycle; the scheduler must not grant a button whose s[i]==0 that cycle.
  - B_WAIT (grant[i]=1): ignores s[i] until terminal count.
    - At terminal: s[i]==1 -> press_pulse[i] next cycle, then B_HIGH.
    - At terminal: s[i]==0 (bounce or re-press) -> B_LOW, no pulse.
- Scheduler FSM:
  - IDLE (busy=0): if any pending, pick the first pending index starting at ptr+1 modulo NUM_BTNS. Register grant, ptr := index, timer := 0, -> TIMING.
  - TIMING (busy=1): timer += 1 each cycle. When timer==DEBOUNCE_COUNT, sample s[granted]. Next cycle: grant cleared, pulse if valid, -> IDLE.
- Timing, with the grant visible in cycle 0:
  - Sample occurs in cycle DEBOUNCE_COUNT.
  - press_pulse is high in cycle DEBOUNCE_COUNT+1 only.
  - The earliest next grant is in cycle DEBOUNCE_COUNT+2.
- Timer never wraps. It is compared for equality and held at 0 in IDLE.
- At most one grant bit and one press_pulse bit are high in any cycle.
- Buttons not granted keep progressing through B_HIGH/B_LOW/B_REQ independently while the timer is busy.
- Reset mid-TIMING: outputs clear immediately and no pulse is issued. After release, a button held low re-enters via B_HIGH -> B_LOW and needs a full release to be requested.
- Unknown FSM encodings recover to B_HIGH / IDLE.

Test Plan (NUM_BTNS=4, DEBOUNCE_COUNT=15):
- Clean press btn[0]: low 6 cycles, then high. Required:
  - pending[0] rises 3 cycles after the release edge.
  - grant[0]=1 for cycles 0..16 relative to its rise.
  - press_pulse[0]=1 in cycle 16 only; one pulse total.
- Bounce btn[1]: released, then low again in grant cycle 5 and held past cycle 15. Required:
  - no pulse; FSM returns to B_LOW.
  - On a later final release: one pulse, exactly 16 cycles after the new grant.
- Simultaneous release of btn[0] and btn[2] (from reset). Required:
  - grant[0] at cycle 0, press_pulse[0] at cycle 16.
  - grant[2] at cycle 17, press_pulse[2] at cycle 33.
- Fairness: after btn[3] is served, btn[0] and btn[3] both pending. Required: btn[0] granted first, btn[3] granted next.
- Withdrawal: btn[2] released while btn[1] timing, then pressed low again before btn[1] finishes. Required:
  - pending[2] drops 3 cycles after the edge.
  - btn[2] is never granted; no press_pulse[2].
- Reset mid-operation: rst_btn low in grant cycle 8 for 3 cycles. Required:
  - grant, busy, pending, press_pulse all 0 asynchronously.
  - No press_pulse for any button until a new full press/release.
